// File: rtl/dccm_if.sv
// dccm_if: LSU-to-DCCM read/write port bundle; master is the LSU, slave is the memory.
interface dccm_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] lsu_dccm_raddr;
    logic            lsu_dccm_rvalid_in;
    logic [XLEN-1:0] lsu_dccm_rdata;
    logic            lsu_dccm_rvalid_out;
    logic [XLEN-1:0] lsu_dccm_waddr;
    logic            lsu_dccm_wen;
    logic [XLEN-1:0] lsu_dccm_wdata;
    logic            dccm_init_busy;
    logic            dccm_rd_err;
    logic            dccm_wr_err;

    modport master (
        output lsu_dccm_raddr, lsu_dccm_rvalid_in, lsu_dccm_waddr, lsu_dccm_wen, lsu_dccm_wdata,
        input  lsu_dccm_rdata, lsu_dccm_rvalid_out, dccm_init_busy, dccm_rd_err, dccm_wr_err
    );
    modport slave (
        input  lsu_dccm_raddr, lsu_dccm_rvalid_in, lsu_dccm_waddr, lsu_dccm_wen, lsu_dccm_wdata,
        output lsu_dccm_rdata, lsu_dccm_rvalid_out, dccm_init_busy, dccm_rd_err, dccm_wr_err
    );
endinterface

// File: rtl/dccm.sv
// dccm: single-cycle word SRAM with post-reset zero-fill sweep and out-of-range error pulses.
module dccm #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
    input logic     clk,
    input logic     rst_n,
    dccm_if.slave   bus
);
    localparam int              AW   = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH_WORDS * 4);

    typedef enum logic {INIT, READY} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   init_idx_q, init_idx_d;
    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] roff, woff, rdata_q, rdata_d, mem_wd;
    logic [AW-1:0]   ridx, widx, mem_idx;
    logic            rin, win, rd_acc, wr_acc, mem_we;
    logic            rvalid_q, rd_err_q, wr_err_q;

    always_comb begin
        roff       = bus.lsu_dccm_raddr - BASE_ADDR;
        woff       = bus.lsu_dccm_waddr - BASE_ADDR;
        rin        = roff < SPAN;
        win        = woff < SPAN;
        ridx       = roff[AW+1:2];
        widx       = woff[AW+1:2];
        rd_acc     = (state_q == READY) && bus.lsu_dccm_rvalid_in;
        wr_acc     = (state_q == READY) && bus.lsu_dccm_wen;
        state_d    = (state_q == INIT && init_idx_q == AW'(DEPTH_WORDS - 1)) ? READY : state_q;
        init_idx_d = (state_q == INIT) ? init_idx_q + AW'(1) : init_idx_q;
        // The init sweep owns the single write port until the array is clear
        mem_we     = (state_q == INIT) || (wr_acc && win);
        mem_idx    = (state_q == INIT) ? init_idx_q : widx;
        mem_wd     = (state_q == INIT) ? '0 : bus.lsu_dccm_wdata;
        // Write-first: a same-cycle write to the read word bypasses the array
        rdata_d    = !rd_acc ? rdata_q :
                     !rin ? '0 :
                     (wr_acc && win && widx == ridx) ? bus.lsu_dccm_wdata : mem[ridx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rd_acc;
            rd_err_q   <= rd_acc && !rin;
            wr_err_q   <= wr_acc && !win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[mem_idx] <= mem_wd;
    end

    assign bus.lsu_dccm_rdata      = rdata_q;
    assign bus.lsu_dccm_rvalid_out = rvalid_q;
    assign bus.dccm_rd_err         = rd_err_q;
    assign bus.dccm_wr_err         = wr_err_q;
    assign bus.dccm_init_busy      = state_q == INIT;
endmodule

// File: tb/tb_dccm.sv
// tb_dccm: directed checks of dccm with BASE_ADDR=0x1000, DEPTH_WORDS=1024.
module tb_dccm;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dccm_if #(.XLEN(32)) bus ();

    dccm #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(BASE)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rv, input logic [31:0] ra, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd);
        bus.lsu_dccm_rvalid_in = rv;
        bus.lsu_dccm_raddr     = ra;
        bus.lsu_dccm_wen       = we;
        bus.lsu_dccm_waddr     = wa;
        bus.lsu_dccm_wdata     = wd;
        cyc();
        bus.lsu_dccm_rvalid_in = 1'b0;
        bus.lsu_dccm_wen       = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (bus.dccm_init_busy && n < 2000) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        int n;
        addrs = '{BASE, BASE + 32'h7FC, BASE + 32'hFFC};
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err, bus.dccm_init_busy} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0001",
                     {bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err, bus.dccm_init_busy});
        end
        checks++;
        if (bus.lsu_dccm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", bus.lsu_dccm_rdata);
        end
        rst_n = 1'b1;
        wait_init(n);
        checks++;
        if (n !== 1024) begin
            errors++;
            $display("FAIL init_len: got %0d cycles want 1024", n);
        end
        foreach (addrs[i]) begin
            req(1'b1, addrs[i], 1'b0, 32'h0, 32'h0);
            checks++;
            if ({bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err} !== 3'b100 || bus.lsu_dccm_rdata !== 32'h0) begin
                errors++;
                $display("FAIL idle_read %h: flags %b data %h want 100 / 0", addrs[i],
                         {bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err}, bus.lsu_dccm_rdata);
            end
            cyc();
            checks++;
            if (bus.lsu_dccm_rvalid_out !== 1'b0) begin
                errors++;
                $display("FAIL idle_read_pulse %h: rvalid %b want 0", addrs[i], bus.lsu_dccm_rvalid_out);
            end
        end
    endtask

    task automatic test_write_read();
        req(1'b0, 32'h0, 1'b1, BASE + 32'h104, 32'hDEADBEEF);
        checks++;
        if ({bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err} !== 3'b000) begin
            errors++;
            $display("FAIL wr_flags: got %b want 000", {bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err});
        end
        req(1'b1, BASE + 32'h107, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err} !== 3'b100 || bus.lsu_dccm_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_rd: flags %b data %h want 100 / deadbeef",
                     {bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err}, bus.lsu_dccm_rdata);
        end
        cyc();
        checks++;
        if (bus.lsu_dccm_rvalid_out !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_pulse: rvalid %b want 0", bus.lsu_dccm_rvalid_out);
        end
    endtask

    task automatic test_back_to_back();
        req(1'b0, 32'h0, 1'b1, BASE + 32'h20, 32'h11111111);
        req(1'b1, BASE + 32'h20, 1'b1, BASE + 32'h20, 32'hCAFEF00D);
        checks++;
        if (bus.lsu_dccm_rvalid_out !== 1'b1 || bus.lsu_dccm_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL bypass: rvalid %b data %h want 1 / cafef00d", bus.lsu_dccm_rvalid_out, bus.lsu_dccm_rdata);
        end
        req(1'b1, BASE + 32'h20, 1'b1, BASE + 32'h24, 32'h24242424);
        checks++;
        if (bus.lsu_dccm_rvalid_out !== 1'b1 || bus.lsu_dccm_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rd_wr_diff: rvalid %b data %h want 1 / cafef00d", bus.lsu_dccm_rvalid_out, bus.lsu_dccm_rdata);
        end
        bus.lsu_dccm_rvalid_in = 1'b1;
        bus.lsu_dccm_raddr = BASE + 32'h20;
        cyc();
        checks++;
        if (bus.lsu_dccm_rvalid_out !== 1'b1 || bus.lsu_dccm_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL b2b_first: rvalid %b data %h want 1 / cafef00d", bus.lsu_dccm_rvalid_out, bus.lsu_dccm_rdata);
        end
        bus.lsu_dccm_raddr = BASE + 32'h24;
        cyc();
        bus.lsu_dccm_rvalid_in = 1'b0;
        checks++;
        if (bus.lsu_dccm_rvalid_out !== 1'b1 || bus.lsu_dccm_rdata !== 32'h24242424) begin
            errors++;
            $display("FAIL b2b_second: rvalid %b data %h want 1 / 24242424", bus.lsu_dccm_rvalid_out, bus.lsu_dccm_rdata);
        end
        cyc();
        checks++;
        if (bus.lsu_dccm_rvalid_out !== 1'b0 || bus.lsu_dccm_rdata !== 32'h24242424) begin
            errors++;
            $display("FAIL rdata_hold: rvalid %b data %h want 0 / 24242424", bus.lsu_dccm_rvalid_out, bus.lsu_dccm_rdata);
        end
    endtask

    task automatic test_out_of_range();
        req(1'b0, 32'h0, 1'b1, BASE, 32'h5A5A0001);
        req(1'b1, 32'h0000_0FFC, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err} !== 3'b110 || bus.lsu_dccm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: flags %b data %h want 110 / 0",
                     {bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err}, bus.lsu_dccm_rdata);
        end
        cyc();
        checks++;
        if (bus.dccm_rd_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_read_pulse: rd_err %b want 0", bus.dccm_rd_err);
        end
        req(1'b0, 32'h0, 1'b1, 32'h0000_2000, 32'hFFFFFFFF);
        checks++;
        if ({bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err} !== 3'b001) begin
            errors++;
            $display("FAIL oor_write: flags %b want 001", {bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err});
        end
        req(1'b1, BASE, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err} !== 3'b100 || bus.lsu_dccm_rdata !== 32'h5A5A0001) begin
            errors++;
            $display("FAIL oor_unchanged: flags %b data %h want 100 / 5a5a0001",
                     {bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err}, bus.lsu_dccm_rdata);
        end
        req(1'b1, BASE + 32'hFFC, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err} !== 3'b100 || bus.lsu_dccm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL last_word: flags %b data %h want 100 / 0",
                     {bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err}, bus.lsu_dccm_rdata);
        end
    endtask

    task automatic test_init_requests();
        int k;
        int bad;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.lsu_dccm_rvalid_in = 1'b1;
        bus.lsu_dccm_wen = 1'b1;
        bus.lsu_dccm_wdata = 32'hFFFFFFFF;
        k = 0;
        bad = 0;
        while (bus.dccm_init_busy && k < 2000) begin
            bus.lsu_dccm_raddr = k[0] ? 32'h0 : BASE + 32'(4 * (k % 1024));
            bus.lsu_dccm_waddr = k[0] ? 32'h0 : BASE + 32'(4 * (1023 - (k % 1024)));
            cyc();
            if ({bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err} !== 3'b000) bad++;
            k++;
        end
        bus.lsu_dccm_rvalid_in = 1'b0;
        bus.lsu_dccm_wen = 1'b0;
        checks++;
        if (k !== 1024) begin
            errors++;
            $display("FAIL init_busy_len: got %0d cycles want 1024", k);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL init_ignored: %0d cycles with response/error flags, want 0", bad);
        end
        bus.lsu_dccm_rvalid_in = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            bus.lsu_dccm_raddr = BASE + 32'(4 * i);
            cyc();
            checks++;
            if (bus.lsu_dccm_rvalid_out !== 1'b1 || bus.lsu_dccm_rdata !== 32'h0) begin
                errors++;
                $display("FAIL zero_word %0d: rvalid %b data %h want 1 / 0", i, bus.lsu_dccm_rvalid_out, bus.lsu_dccm_rdata);
            end
        end
        bus.lsu_dccm_rvalid_in = 1'b0;
        cyc();
        checks++;
        if (bus.lsu_dccm_rvalid_out !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end: rvalid %b want 0", bus.lsu_dccm_rvalid_out);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        req(1'b0, 32'h0, 1'b1, BASE + 32'h40, 32'hA5A5A5A5);
        req(1'b1, BASE + 32'h40, 1'b0, 32'h0, 32'h0);
        checks++;
        if (bus.lsu_dccm_rdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL mid_pre: data %h want a5a5a5a5", bus.lsu_dccm_rdata);
        end
        rst_n = 1'b0;
        req(1'b1, BASE + 32'h40, 1'b1, BASE + 32'h44, 32'h00000077);
        checks++;
        if ({bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err, bus.dccm_init_busy} !== 4'b0001 || bus.lsu_dccm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: flags %b data %h want 0001 / 0",
                     {bus.lsu_dccm_rvalid_out, bus.dccm_rd_err, bus.dccm_wr_err, bus.dccm_init_busy}, bus.lsu_dccm_rdata);
        end
        rst_n = 1'b1;
        wait_init(n);
        checks++;
        if (n !== 1024) begin
            errors++;
            $display("FAIL mid_init_len: got %0d cycles want 1024", n);
        end
        req(1'b1, BASE + 32'h40, 1'b0, 32'h0, 32'h0);
        checks++;
        if (bus.lsu_dccm_rvalid_out !== 1'b1 || bus.lsu_dccm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_cleared: rvalid %b data %h want 1 / 0", bus.lsu_dccm_rvalid_out, bus.lsu_dccm_rdata);
        end
        req(1'b1, BASE + 32'h44, 1'b0, 32'h0, 32'h0);
        checks++;
        if (bus.lsu_dccm_rvalid_out !== 1'b1 || bus.lsu_dccm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_write_dropped: rvalid %b data %h want 1 / 0", bus.lsu_dccm_rvalid_out, bus.lsu_dccm_rdata);
        end
    endtask

    initial begin
        bus.lsu_dccm_raddr     = '0;
        bus.lsu_dccm_rvalid_in = 1'b0;
        bus.lsu_dccm_waddr     = '0;
        bus.lsu_dccm_wen       = 1'b0;
        bus.lsu_dccm_wdata     = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_init_requests();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
